// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 serial controller.
// The config word layout follows the ADC's 6-bit DIN format, MSB first.
package ltc2308_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConvPulse,
    StConvWait,
    StShift,
    StEmit
  } state_e;

  localparam int unsigned RES_BITS = 12;
  localparam int unsigned CFG_BITS = 6;
  localparam int unsigned NUM_CH   = 8;

  localparam int unsigned SDI_SD  = 5;
  localparam int unsigned SDI_OS  = 4;
  localparam int unsigned SDI_S1  = 3;
  localparam int unsigned SDI_S0  = 2;
  localparam int unsigned SDI_UNI = 1;
  localparam int unsigned SDI_SLP = 0;

  // Single-ended config for one channel; sleep is never requested.
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch, input logic uni);
    logic [CFG_BITS-1:0] w;
    w          = '0;
    w[SDI_SD]  = 1'b1;
    w[SDI_OS]  = ch[0];
    w[SDI_S1]  = ch[2];
    w[SDI_S0]  = ch[1];
    w[SDI_UNI] = uni;
    w[SDI_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/adc_ch_rr.sv
// Round-robin channel picker: first set mask bit strictly after ptr_i, wrapping 7->0.
// The pointer's own bit is considered last, so a single-bit mask always re-selects it.
module adc_ch_rr
  import ltc2308_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [2:0]        ptr_i,
  output logic [2:0]        ch_o,
  output logic              found_o
);

  logic [2:0] idx;

  always_comb begin
    ch_o    = ptr_i;
    found_o = 1'b0;
    idx     = '0;
    // Scan from farthest to nearest so the nearest set bit wins.
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr_i + 3'(i);
      if (mask_i[idx]) begin
        ch_o    = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ltc2308_ctrl.sv
// LTC2308 controller: round-robin conversions over ch_mask, config out on SDI while the
// previous result comes back on SDO, results presented as a valid/ready stream.
module ltc2308_ctrl
  import ltc2308_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CONVST_CYCLES = 2,
  parameter int unsigned TCONV_CYCLES  = 80
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                uni,
  output logic [RES_BITS-1:0] sample_data,
  output logic [2:0]          sample_ch,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy,
  output logic                adc_CONVST,
  output logic                adc_SCK,
  output logic                adc_SDI,
  input  logic                adc_SDO
);

  localparam int unsigned CntW = 16;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic [RES_BITS-1:0] tx_q, tx_d;
  logic [RES_BITS-1:0] rx_q, rx_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          cur_ch_q, cur_ch_d;
  logic                uni_q, uni_d;
  logic                primed_q, primed_d;
  logic [RES_BITS-1:0] data_q, data_d;
  logic [2:0]          ch_q, ch_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [2:0]          rr_ch;
  logic                rr_found;
  logic                run;
  logic [CFG_BITS-1:0] cfg;

  adc_ch_rr u_ch_rr (
    .mask_i  (ch_mask),
    .ptr_i   (ptr_q),
    .ch_o    (rr_ch),
    .found_o (rr_found)
  );

  assign run = enable & rr_found;
  assign cfg = cfg_word(ptr_q, uni_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ptr_d     = ptr_q;
    cur_ch_d  = cur_ch_q;
    uni_d     = uni_q;
    primed_d  = primed_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StConvPulse;
          cnt_d   = '0;
          ptr_d   = rr_ch;
          uni_d   = uni;
        end
      end
      StConvPulse: begin
        if (cnt_q == CntW'(CONVST_CYCLES - 1)) begin
          state_d = StConvWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StConvWait: begin
        if (cnt_q == CntW'(TCONV_CYCLES - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          sdi_d   = cfg[CFG_BITS-1];
          tx_d    = {cfg[CFG_BITS-2:0], {(RES_BITS - CFG_BITS + 1){1'b0}}};
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // This edge raises SCK: capture the bit the ADC is presenting.
            rx_d = {rx_q[RES_BITS-2:0], adc_SDO};
          end else begin
            sdi_d = tx_q[RES_BITS-1];
            tx_d  = {tx_q[RES_BITS-2:0], 1'b0};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'(RES_BITS - 1)) begin
              state_d = StEmit;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEmit: begin
        // The result just read belongs to the channel configured one frame earlier.
        if (primed_q) begin
          if (!valid_q || sample_ready) begin
            data_d  = rx_q;
            ch_d    = cur_ch_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        primed_d = 1'b1;
        cur_ch_d = ptr_q;
        if (run) begin
          state_d = StConvPulse;
          cnt_d   = '0;
          ptr_d   = rr_ch;
          uni_d   = uni;
        end else begin
          state_d  = StIdle;
          primed_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      ptr_q     <= 3'd7;
      cur_ch_q  <= '0;
      uni_q     <= 1'b0;
      primed_q  <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ptr_q     <= ptr_d;
      cur_ch_q  <= cur_ch_d;
      uni_q     <= uni_d;
      primed_q  <= primed_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != StIdle);
  assign adc_CONVST   = (state_q == StConvPulse);
  assign adc_SCK      = sck_q;
  assign adc_SDI      = sdi_q;

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: behavioural LTC2308 model plus a queue of expected samples
// checked on every stream handshake.
module tb_ltc2308_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        uni = 1'b0;
  logic        sample_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        overrun;
  logic        busy;
  logic        adc_CONVST;
  logic        adc_SCK;
  logic        adc_SDI;
  logic        adc_SDO;

  ltc2308_ctrl dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .ch_mask       (ch_mask),
    .uni           (uni),
    .sample_data   (sample_data),
    .sample_ch     (sample_ch),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .busy          (busy),
    .adc_CONVST    (adc_CONVST),
    .adc_SCK       (adc_SCK),
    .adc_SDI       (adc_SDI),
    .adc_SDO       (adc_SDO)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- ADC model ----------------
  bit          mode_rr = 1'b0;
  logic [11:0] sdo_sr = '0;
  logic [11:0] sdi_sr = '0;
  logic [11:0] last_sdi = '0;
  int          sdi_bits = 0;
  int          last_bits = 0;
  int          frames = 0;

  function automatic logic [11:0] res_fn(input logic [2:0] ch, input bit rr);
    return rr ? {1'b0, ch, 1'b0, ch, 1'b0, ch} : 12'hA5C;
  endfunction

  assign adc_SDO = sdo_sr[11];

  // Conversion at CONVST uses the config shifted in during the previous frame.
  always @(posedge adc_CONVST or posedge adc_SCK or negedge adc_SCK) begin
    if (adc_CONVST) begin
      last_sdi  <= sdi_sr;
      last_bits <= sdi_bits;
      sdo_sr    <= res_fn({sdi_sr[9], sdi_sr[8], sdi_sr[10]}, mode_rr);
      sdi_bits  <= 0;
      frames    <= frames + 1;
    end else if (adc_SCK) begin
      sdi_sr   <= {sdi_sr[10:0], adc_SDI};
      sdi_bits <= sdi_bits + 1;
    end else begin
      sdo_sr <= {sdo_sr[10:0], 1'b0};
    end
  end

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          spc_chk = 1'b0;
  bit          sdi_chk = 1'b0;
  logic [11:0] sdi_exp = '0;
  int          prev_cons = -1;
  int          last_cons = -1;

  task automatic step();
    logic [14:0] e;
    @(negedge clk_clk);
    if (mon_en && sample_valid && sample_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sample: got ch%0d/%h, required none", sample_ch, sample_data);
      end else begin
        e = exp_q.pop_front();
        if ({sample_ch, sample_data} !== e) begin
          n_fail++;
          $display("FAIL sample: got ch%0d/%h, required ch%0d/%h", sample_ch, sample_data,
                   e[14:12], e[11:0]);
        end
      end
      if (spc_chk && prev_cons >= 0) begin
        n_tests++;
        if (cyc - prev_cons != 131) begin
          n_fail++;
          $display("FAIL valid_spacing: got %0d cycles, required 131", cyc - prev_cons);
        end
      end
      if (sdi_chk) begin
        n_tests++;
        if (last_sdi !== sdi_exp || last_bits != 12) begin
          n_fail++;
          $display("FAIL sdi_word: got %h (%0d bits), required %h (12 bits)", last_sdi,
                   last_bits, sdi_exp);
        end
      end
      prev_cons = cyc;
      last_cons = cyc;
    end
  endtask

  task automatic wait_empty(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d samples pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b, required 0", name, busy);
    end
  endtask

  task automatic do_reset(input int n);
    reset_reset_n = 1'b0;
    repeat (n) step();
    reset_reset_n = 1'b1;
  endtask

  // Expect the in-flight frame's sample, then let the controller wind down.
  task automatic stop_run(input logic [14:0] last, input string name);
    exp_q.push_back(last);
    enable = 1'b0;
    wait_empty(300, name);
    wait_idle(300, name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int f0;
    bit busy_seen;
    enable  = 1'b1;
    ch_mask = 8'hFF;
    reset_reset_n = 1'b0;
    repeat (5) step();
    n_tests++;
    if ({adc_CONVST, adc_SCK, adc_SDI, sample_valid, overrun, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got CONVST/SCK/SDI/valid/ovr/busy=%b, required 000000",
               {adc_CONVST, adc_SCK, adc_SDI, sample_valid, overrun, busy});
    end
    n_tests++;
    if (sample_data !== 12'h000 || sample_ch !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got ch%0d/%h, required ch0/000", sample_ch, sample_data);
    end
    enable = 1'b0;
    reset_reset_n = 1'b1;
    f0 = frames;
    busy_seen = 1'b0;
    repeat (50) begin
      step();
      if (busy) busy_seen = 1'b1;
    end
    n_tests++;
    if (busy_seen || frames != f0) begin
      n_fail++;
      $display("FAIL idle_disabled: got busy_seen=%b convst_pulses=%0d, required 0/0",
               busy_seen, frames - f0);
    end
  endtask

  task automatic test_single();
    logic [2:0] ch;
    ch      = 3'd3;
    mode_rr = 1'b0;
    ch_mask = 8'h08;
    uni     = 1'b1;
    sample_ready = 1'b1;
    sdi_exp = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b0};
    repeat (3) exp_q.push_back({ch, 12'hA5C});
    prev_cons = -1;
    spc_chk = 1'b1;
    sdi_chk = 1'b1;
    mon_en  = 1'b1;
    enable  = 1'b1;
    wait_empty(900, "single");
    stop_run({ch, 12'hA5C}, "single_stop");
    spc_chk = 1'b0;
    sdi_chk = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] p;
    logic [2:0] idx;
    logic [2:0] seq[6];
    do_reset(2);
    mode_rr = 1'b1;
    ch_mask = 8'h85;
    uni     = 1'b0;
    sample_ready = 1'b1;
    p = 3'd7;
    for (int k = 0; k < 6; k++) begin
      for (int j = 1; j <= 8; j++) begin
        idx = p + 3'(j);
        if (ch_mask[idx]) begin
          p = idx;
          break;
        end
      end
      seq[k] = p;
    end
    for (int k = 0; k < 5; k++) exp_q.push_back({seq[k], res_fn(seq[k], 1'b1)});
    enable = 1'b1;
    wait_empty(900, "round_robin");
    stop_run({seq[5], res_fn(seq[5], 1'b1)}, "rr_stop");
  endtask

  task automatic test_backpressure();
    int v0;
    bit stable;
    do_reset(2);
    mon_en  = 1'b0;
    mode_rr = 1'b1;
    ch_mask = 8'h08;
    sample_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 400 && !sample_valid; i++) step();
    v0 = cyc;
    n_tests++;
    if (sample_valid !== 1'b1 || sample_ch !== 3'd3 || sample_data !== 12'h333) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b ch%0d/%h, required v=1 ch3/333", sample_valid,
               sample_ch, sample_data);
    end
    stable = 1'b1;
    while (cyc < v0 + 300) begin
      step();
      if (sample_valid !== 1'b1 || sample_data !== 12'h333 || sample_ch !== 3'd3)
        stable = 1'b0;
      if (cyc == v0 + 130) begin
        n_tests++;
        if (overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_no_overrun_yet: got %b, required 0", overrun);
        end
      end
      if (cyc == v0 + 131) begin
        n_tests++;
        if (overrun !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_overrun_set: got %b, required 1", overrun);
        end
      end
      if (cyc == v0 + 200) overrun_clr = 1'b1;
      if (cyc == v0 + 201) begin
        overrun_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_overrun_clr: got %b, required 0", overrun);
        end
      end
      // Clear coincides with the third EMIT: the new drop must win.
      if (cyc == v0 + 261) overrun_clr = 1'b1;
      if (cyc == v0 + 262) begin
        overrun_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_set_beats_clr: got %b, required 1", overrun);
        end
      end
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_hold: got unstable sample while stalled, required ch3/333 held");
    end
    sample_ready = 1'b1;
    enable = 1'b0;
    wait_idle(300, "bp");
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0 || sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_final: got ovr=%b valid=%b, required 0/0", overrun, sample_valid);
    end
  endtask

  task automatic test_enable_drop();
    int f0;
    int c0;
    do_reset(2);
    mode_rr = 1'b1;
    ch_mask = 8'h08;
    sample_ready = 1'b1;
    mon_en = 1'b1;
    exp_q.push_back({3'd3, 12'h333});
    f0 = frames;
    enable = 1'b1;
    for (int i = 0; i < 400 && frames < f0 + 2; i++) step();
    for (int i = 0; i < 200 && sdi_bits < 5; i++) step();
    enable = 1'b0;
    wait_empty(300, "drop");
    wait_idle(300, "drop");
    repeat (20) step();
    n_tests++;
    if (frames != f0 + 2) begin
      n_fail++;
      $display("FAIL drop_frames: got %0d frames, required 2", frames - f0);
    end
    // Re-enable: one IDLE cycle, a discarded priming frame, then the real one.
    exp_q.push_back({3'd3, 12'h333});
    c0 = cyc;
    enable = 1'b1;
    wait_empty(600, "reenable");
    n_tests++;
    if (last_cons - c0 != 1 + 2 * 131) begin
      n_fail++;
      $display("FAIL reenable_latency: got %0d cycles, required %0d", last_cons - c0,
               1 + 2 * 131);
    end
    stop_run({3'd3, 12'h333}, "reenable_stop");
  endtask

  task automatic test_reset_mid();
    int f0;
    int c0;
    mode_rr = 1'b1;
    ch_mask = 8'h08;
    sample_ready = 1'b1;
    mon_en = 1'b1;
    f0 = frames;
    enable = 1'b1;
    for (int i = 0; i < 400 && !(frames > f0 && !adc_CONVST); i++) step();
    repeat (10) step();
    reset_reset_n = 1'b0;
    step();
    n_tests++;
    if ({adc_CONVST, adc_SCK, busy, sample_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got CONVST/SCK/busy/valid=%b, required 0000",
               {adc_CONVST, adc_SCK, busy, sample_valid});
    end
    reset_reset_n = 1'b1;
    exp_q.push_back({3'd3, 12'h333});
    c0 = cyc;
    wait_empty(700, "reset_restart");
    n_tests++;
    if (last_cons - c0 != 1 + 2 * 131) begin
      n_fail++;
      $display("FAIL reset_reprime: got %0d cycles, required %0d", last_cons - c0,
               1 + 2 * 131);
    end
    stop_run({3'd3, 12'h333}, "reset_stop");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
